// File: rtl/sram_arb_multi.sv
// sram_arb_multi: arbitrates NUM_MASTERS Avalon-style masters onto one
// asynchronous SRAM. It supports fixed-select and round-robin arbitration,
// and a programmable number of cycles per access. All SRAM pins are registered.
//
// Handshake: a master asserts m_read/m_write (write wins if both) and holds
// it while m_waitrequest is high. m_waitrequest drops for exactly one cycle,
// which is the last ACCESS cycle of that master's access. That cycle is the
// transfer. Read data returns one cycle later, qualified by a one-cycle
// m_readdataready pulse on the granted master's bit.
module sram_arb_multi #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_MASTERS   = 2,
  parameter int SEL_WIDTH     = 1,
  parameter int ACCESS_CYCLES = 2,
  localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mode,
  input  logic [SEL_WIDTH-1:0]              sel,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
  output logic [DATA_WIDTH-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]            m_readdataready,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic                              busy,
  output logic                              dbg_state,
  output logic [ADDR_WIDTH-1:0]             sram_address,
  output logic [DATA_WIDTH-1:0]             sram_dout,
  input  logic [DATA_WIDTH-1:0]             sram_din,
  output logic                              sram_doe,
  output logic                              sram_ce_n,
  output logic                              sram_oe_n,
  output logic                              sram_we_n,
  output logic [BE_WIDTH-1:0]               sram_be_n
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [3:0]              count_q, count_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [BE_WIDTH-1:0]     be_n_q, be_n_d;
  logic                    doe_q, doe_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_MASTERS-1:0]  rdr_q, rdr_d;
  logic [NUM_MASTERS-1:0]  req;
  logic                    last_cycle;
  logic                    found;
  int                      pick;
  int                      idx;

  assign req        = m_read | m_write;
  assign last_cycle = (state_q == ACCESS) && (count_q == LAST_CNT);

  // Per-master stall: released only in the granted master's final ACCESS cycle
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_waitrequest[i] = req[i] & ~(last_cycle && (int'(grant_q) == i));
    end
  end

  // Arbitration, access sequencing and next values of the registered pins
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    be_n_d       = be_n_q;
    doe_d        = doe_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    rdata_d      = rdata_q;
    rdr_d        = '0;
    found        = 1'b0;
    pick         = 0;
    idx          = 0;
    case (state_q)
      IDLE: begin
        // Pins sit idle for this cycle, which gives the bus turnaround.
        addr_d  = '0;
        dout_d  = '0;
        be_n_d  = '1;
        doe_d   = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        count_d = '0;
        if (!mode) begin
          // An out-of-range sel matches no index, so no master is granted.
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if ((int'(sel) == i) && req[i]) begin
              found = 1'b1;
              pick  = i;
            end
          end
        end else begin
          // The search starts just after the last grant and wraps around.
          for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx]) begin
              found = 1'b1;
              pick  = idx;
            end
          end
        end
        if (found) begin
          state_d = ACCESS;
          grant_d = GW'(pick);
          if (mode) last_grant_d = GW'(pick);
          is_wr_d = m_write[pick];
          addr_d  = m_address[pick*ADDR_WIDTH +: ADDR_WIDTH];
          be_n_d  = ~m_byteenable[pick*BE_WIDTH +: BE_WIDTH];
          ce_n_d  = 1'b0;
          if (m_write[pick]) begin
            we_n_d = 1'b0;
            doe_d  = 1'b1;
            dout_d = m_writedata[pick*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            oe_n_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (count_q == LAST_CNT) begin
          state_d = IDLE;
          addr_d  = '0;
          dout_d  = '0;
          be_n_d  = '1;
          doe_d   = 1'b0;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          count_d = '0;
          if (!is_wr_q) begin
            rdata_d = sram_din;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              rdr_d[i] = (int'(grant_q) == i);
            end
          end
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered pins; reset drops every strobe immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_MASTERS - 1);
      count_q      <= '0;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      be_n_q       <= '1;
      doe_q        <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      rdata_q      <= '0;
      rdr_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      be_n_q       <= be_n_d;
      doe_q        <= doe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      rdata_q      <= rdata_d;
      rdr_q        <= rdr_d;
    end
  end

  assign busy            = (state_q == ACCESS);
  assign dbg_state       = state_q;
  assign sram_address    = addr_q;
  assign sram_dout       = dout_q;
  assign sram_be_n       = be_n_q;
  assign sram_doe        = doe_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign m_readdata      = rdata_q;
  assign m_readdataready = rdr_q;

endmodule
